compression_chain_scheduler: RTL and testbench

//  Shares one compression chain (12-bit->dB converter, gain computer, level detector) between
//  NUM_CH drum-pad sample streams. Latches each channel's sample, grants the chain round-robin,

---
 rtl/compressor_pkg.sv | 44 ++++
 rtl/round_robin_picker.sv | 49 ++++
 rtl/compression_chain_scheduler.sv | 235 +++++++++++++++++++++++
 tb/tb_compression_chain_scheduler.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compressor_pkg.sv
// ----------------------------------------------------------------------------
// compressor_pkg
// Shared definitions for the drum-pad compression chain scheduler:
//   - state_e  : scheduler FSM encoding (IDLE / ISSUE / WAIT / STORE)
//   - amount_e : 2-bit compression_amount encoding understood by the
//                compression_gain_computer stage
//   - default widths / channel count / timeout used as parameter defaults
//   - cnt_width: width of the WAIT-state abort counter (8..16 bits)
// ----------------------------------------------------------------------------
package compressor_pkg;

    localparam int NUM_CH_DEF   = 4;
    localparam int SAMPLE_W_DEF = 12;
    localparam int GAIN_W_DEF   = 9;
    localparam int TIMEOUT_DEF  = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        AMT_NONE   = 2'd0,
        AMT_LIGHT  = 2'd1,
        AMT_MEDIUM = 2'd2,
        AMT_HEAVY  = 2'd3
    } amount_e;

    // Abort counter is at least 8 bits and never wider than 16 bits.
    function automatic int cnt_width(input int max_count);
        int w;
        w = $clog2(max_count + 1);
        if (w < 8) begin
            w = 8;
        end
        if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage

// File: rtl/round_robin_picker.sv
// ----------------------------------------------------------------------------
// round_robin_picker
// Combinational round-robin arbiter. Searches the pending vector starting at
// last_grant+1 and wrapping, so the most recently served channel has the
// lowest priority on the next pick.
// Ports:
//   pending    in  NUM_CH   request vector
//   last_grant in  IDX_W    channel served most recently
//   grant      out IDX_W    selected channel (0 when nothing pending)
//   any        out 1        at least one request present
// ----------------------------------------------------------------------------
module round_robin_picker
    import compressor_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [IDX_W-1:0]  last_grant,
    output logic [IDX_W-1:0]  grant,
    output logic              any
);

    always_comb begin
        logic             found;
        int               idx;
        logic [IDX_W-1:0] idx_l;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        idx_l = '0;
        // Offsets 1..NUM_CH: offset NUM_CH lands back on last_grant itself,
        // which is picked only if it is the sole requester.
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            idx_l = IDX_W'(idx);
            if (!found && pending[idx_l]) begin
                found = 1'b1;
                grant = idx_l;
            end
        end
    end

    assign any = |pending;

endmodule

// File: rtl/compression_chain_scheduler.sv
// ----------------------------------------------------------------------------
// compression_chain_scheduler
// Shares one compression chain (dB converter -> gain computer -> level
// detector) between NUM_CH drum-pad sample streams. Each channel's sample is
// latched, the chain is granted round-robin, started with a 1-cycle pulse,
// and the returned gain is written back to that channel's gain_out slot.
//
// Handshake: ch_valid[i] is a single-cycle strobe with no back-pressure; a
// new strobe on a still-pending channel overwrites it and flags overrun[i].
// chain_start is a 1-cycle pulse; chain_sample/chain_amount stay stable from
// that cycle until the gain is stored. chain_done is honoured only while
// waiting and chain_gain is sampled in that same cycle.
//
// Ports:
//   clock, reset              system clock, async active-high reset
//   ch_valid/ch_sample/ch_amount  per-channel capture strobe and data
//   clear_flags               clears overrun and timeout_err
//   chain_start/chain_sample/chain_amount  request to the chain
//   chain_done/chain_gain     response from the chain
//   gain_out/gain_valid       per-channel result and update pulse
//   overrun, timeout_err      sticky error flags
//   busy                      FSM not in IDLE
//   dbg_state                 current FSM state
//
// Build option: define COMP_SCHED_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles (sets timeout_err, no gain written). Without it the
// scheduler waits for chain_done indefinitely and timeout_err is tied low.
// ----------------------------------------------------------------------------
module compression_chain_scheduler
    import compressor_pkg::*;
#(
    parameter int NUM_CH         = NUM_CH_DEF,
    parameter int SAMPLE_W       = SAMPLE_W_DEF,
    parameter int GAIN_W         = GAIN_W_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_valid,
    input  logic [NUM_CH*SAMPLE_W-1:0] ch_sample,
    input  logic [NUM_CH*2-1:0]        ch_amount,
    input  logic                       clear_flags,
    output logic                       chain_start,
    output logic [SAMPLE_W-1:0]        chain_sample,
    output logic [1:0]                 chain_amount,
    input  logic                       chain_done,
    input  logic [GAIN_W-1:0]          chain_gain,
    output logic [NUM_CH*GAIN_W-1:0]   gain_out,
    output logic [NUM_CH-1:0]          gain_valid,
    output logic [NUM_CH-1:0]          overrun,
    output logic                       timeout_err,
    output logic                       busy,
    output state_e                     dbg_state
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           grant_q, grant_d;
    logic [IDX_W-1:0]           last_grant_q, last_grant_d;
    logic [NUM_CH-1:0]          pending_q, pending_d;
    logic [NUM_CH-1:0]          overrun_q, overrun_d;
    logic [SAMPLE_W-1:0]        samp_q [NUM_CH];
    logic [SAMPLE_W-1:0]        samp_d [NUM_CH];
    logic [1:0]                 amt_q [NUM_CH];
    logic [1:0]                 amt_d [NUM_CH];
    logic [SAMPLE_W-1:0]        chain_sample_q, chain_sample_d;
    logic [1:0]                 chain_amount_q, chain_amount_d;
    logic [GAIN_W-1:0]          gain_cap_q, gain_cap_d;
    logic [NUM_CH*GAIN_W-1:0]   gain_out_q, gain_out_d;
    logic [NUM_CH-1:0]          gain_valid_q, gain_valid_d;

    logic [IDX_W-1:0]           pick_grant;
    logic                       pick_any;

`ifdef COMP_SCHED_TIMEOUT_EN
    localparam int TO_W = cnt_width(TIMEOUT_CYCLES);
    logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
    logic                       timeout_err_q, timeout_err_d;
    logic                       timeout_set;
`endif

    round_robin_picker #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_picker (
        .pending    (pending_q),
        .last_grant (last_grant_q),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        chain_sample_d = chain_sample_q;
        chain_amount_d = chain_amount_q;
        gain_cap_d     = gain_cap_q;
        gain_out_d     = gain_out_q;
        gain_valid_d   = '0;
        pending_d      = pending_q;
        for (int i = 0; i < NUM_CH; i++) begin
            samp_d[i] = samp_q[i];
            amt_d[i]  = amt_q[i];
        end
`ifdef COMP_SCHED_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        timeout_set = 1'b0;
`endif

        // The issued channel is released first so that a capture in the same
        // cycle re-arms it with the fresh sample.
        if (state_q == ST_ISSUE) begin
            pending_d[grant_q] = 1'b0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_valid[i]) begin
                samp_d[i]    = ch_sample[i*SAMPLE_W +: SAMPLE_W];
                amt_d[i]     = ch_amount[i*2 +: 2];
                pending_d[i] = 1'b1;
            end
        end

        // Set beats clear when both happen together.
        overrun_d = clear_flags ? '0 : overrun_q;
        overrun_d = overrun_d | (ch_valid & pending_q);

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_grant;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                chain_sample_d = samp_q[grant_q];
                chain_amount_d = amt_q[grant_q];
                state_d        = ST_WAIT;
`ifdef COMP_SCHED_TIMEOUT_EN
                to_cnt_d       = '0;
`endif
            end
            ST_WAIT: begin
                if (chain_done) begin
                    gain_cap_d = chain_gain;
                    state_d    = ST_STORE;
                end
`ifdef COMP_SCHED_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    // Abandon this request; rotation still moves past it.
                    timeout_set  = 1'b1;
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            ST_STORE: begin
                gain_out_d[grant_q*GAIN_W +: GAIN_W] = gain_cap_q;
                gain_valid_d[grant_q]                = 1'b1;
                last_grant_d                         = grant_q;
                state_d                              = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef COMP_SCHED_TIMEOUT_EN
        timeout_err_d = (clear_flags ? 1'b0 : timeout_err_q) | timeout_set;
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            grant_q        <= '0;
            last_grant_q   <= IDX_W'(NUM_CH - 1);
            pending_q      <= '0;
            overrun_q      <= '0;
            chain_sample_q <= '0;
            chain_amount_q <= '0;
            gain_cap_q     <= '0;
            gain_out_q     <= '0;
            gain_valid_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                samp_q[i] <= '0;
                amt_q[i]  <= '0;
            end
`ifdef COMP_SCHED_TIMEOUT_EN
            to_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            pending_q      <= pending_d;
            overrun_q      <= overrun_d;
            chain_sample_q <= chain_sample_d;
            chain_amount_q <= chain_amount_d;
            gain_cap_q     <= gain_cap_d;
            gain_out_q     <= gain_out_d;
            gain_valid_q   <= gain_valid_d;
            for (int i = 0; i < NUM_CH; i++) begin
                samp_q[i] <= samp_d[i];
                amt_q[i]  <= amt_d[i];
            end
`ifdef COMP_SCHED_TIMEOUT_EN
            to_cnt_q      <= to_cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // During ISSUE the chain sees the buffer directly so the start pulse and
    // its data line up; the registered copy holds it through WAIT/STORE.
    assign chain_start  = (state_q == ST_ISSUE);
    assign chain_sample = (state_q == ST_ISSUE) ? samp_q[grant_q] : chain_sample_q;
    assign chain_amount = (state_q == ST_ISSUE) ? amt_q[grant_q]  : chain_amount_q;
    assign gain_out     = gain_out_q;
    assign gain_valid   = gain_valid_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != ST_IDLE);
    assign dbg_state    = state_q;

`ifdef COMP_SCHED_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_compression_chain_scheduler.sv
// ----------------------------------------------------------------------------
// tb_compression_chain_scheduler
// Bench for compression_chain_scheduler with a behavioural chain model.
// Expected chain requests and expected gain writes are queued when stimulus
// is driven and consumed by a negedge monitor. Build with
// COMP_SCHED_TIMEOUT_EN to exercise the WAIT abort path.
// ----------------------------------------------------------------------------
module tb_compression_chain_scheduler;
    import compressor_pkg::*;

    localparam int NCH = 4;
    localparam int SW  = 12;
    localparam int GW  = 9;
`ifdef COMP_SCHED_TIMEOUT_EN
    localparam int TO  = 20;
`else
    localparam int TO  = 255;
`endif

    logic              clock;
    logic              reset;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*SW-1:0] ch_sample;
    logic [NCH*2-1:0]  ch_amount;
    logic              clear_flags;
    logic              chain_start;
    logic [SW-1:0]     chain_sample;
    logic [1:0]        chain_amount;
    logic              chain_done;
    logic [GW-1:0]     chain_gain;
    logic [NCH*GW-1:0] gain_out;
    logic [NCH-1:0]    gain_valid;
    logic [NCH-1:0]    overrun;
    logic              timeout_err;
    logic              busy;
    state_e            dbg_state;

    compression_chain_scheduler #(
        .NUM_CH         (NCH),
        .SAMPLE_W       (SW),
        .GAIN_W         (GW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ch_valid     (ch_valid),
        .ch_sample    (ch_sample),
        .ch_amount    (ch_amount),
        .clear_flags  (clear_flags),
        .chain_start  (chain_start),
        .chain_sample (chain_sample),
        .chain_amount (chain_amount),
        .chain_done   (chain_done),
        .chain_gain   (chain_gain),
        .gain_out     (gain_out),
        .gain_valid   (gain_valid),
        .overrun      (overrun),
        .timeout_err  (timeout_err),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    logic [SW+1:0] exp_iss_q[$];   // {amount, sample}
    logic [GW+1:0] exp_gv_q[$];    // {channel, gain}

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Chain model transfer function: gain = (sample >>> 3) + 91.
    function automatic logic [GW-1:0] gain_fn(input logic [SW-1:0] s);
        logic signed [SW-1:0] t;
        t = ($signed(s) >>> 3) + 12'sd91;
        return t[GW-1:0];
    endfunction

    task automatic push_issue(input logic [SW-1:0] s, input logic [1:0] a);
        exp_iss_q.push_back({a, s});
    endtask

    task automatic push_gain(input int ch, input logic [SW-1:0] s);
        logic [1:0] c;
        c = ch[1:0];
        exp_gv_q.push_back({c, gain_fn(s)});
    endtask

    // ---------------- chain model ----------------
    logic model_en    = 1'b1;
    int   model_delay = 40;
    int   model_hold  = 1;
    int   spur_go     = 0;
    int   spur_len    = 1;
    int   done_cyc    = 0;

    initial begin
        int            spur_seen;
        logic [SW-1:0] s;
        spur_seen  = 0;
        chain_done = 1'b0;
        chain_gain = '0;
        forever begin
            @(negedge clock);
            if (spur_go != spur_seen) begin
                spur_seen  = spur_go;
                chain_gain = 9'h0AA;
                chain_done = 1'b1;
                repeat (spur_len) @(negedge clock);
                chain_done = 1'b0;
            end else if (model_en && chain_start && !reset) begin
                s = chain_sample;
                repeat (model_delay) @(negedge clock);
                chain_gain = gain_fn(s);
                chain_done = 1'b1;
                done_cyc   = cyc;
                repeat (model_hold) @(negedge clock);
                chain_done = 1'b0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic [SW+1:0] e_iss;
    logic [GW+1:0] e_gv;
    int            mch;
    int            gv_cnt [NCH];
    int            gv_total = 0;
    int            gv_cyc   = 0;

    initial for (int i = 0; i < NCH; i++) gv_cnt[i] = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (chain_start) begin
                if (exp_iss_q.size() == 0) begin
                    check("start_unexpected", 32'(chain_start), 32'd0);
                end else begin
                    e_iss = exp_iss_q.pop_front();
                    check("chain_sample", 32'(chain_sample), 32'(e_iss[SW-1:0]));
                    check("chain_amount", 32'(chain_amount), 32'(e_iss[SW+1:SW]));
                end
            end
            if (gain_valid != '0) begin
                gv_total++;
                gv_cyc = cyc;
                if (exp_gv_q.size() == 0) begin
                    check("gv_unexpected", 32'(gain_valid), 32'd0);
                end else begin
                    e_gv = exp_gv_q.pop_front();
                    mch  = int'(e_gv[GW+1:GW]);
                    gv_cnt[mch]++;
                    check("gv_onehot", 32'(gain_valid), 32'(1 << mch));
                    check("gain_out", 32'(gain_out[mch*GW +: GW]), 32'(e_gv[GW-1:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic strobe();
        tick(1);
        ch_valid    = '0;
        clear_flags = 1'b0;
    endtask

    task automatic load_ch(input int ch, input logic [SW-1:0] s, input logic [1:0] a);
        ch_valid[ch]            = 1'b1;
        ch_sample[ch*SW +: SW]  = s;
        ch_amount[ch*2 +: 2]    = a;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_iss_q.size() != 0 || exp_gv_q.size() != 0 || busy) && n < budget) begin
            @(posedge clock);
            n++;
        end
        #1;
        check(tag, 32'(exp_iss_q.size() == 0 && exp_gv_q.size() == 0 && !busy), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- tests ----------------
    int gv_before;
    int n_wait;

    initial begin
        reset       = 1'b1;
        ch_valid    = '0;
        ch_sample   = '0;
        ch_amount   = '0;
        clear_flags = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);

        // Reset state
        check("rst_busy",        32'(busy),         32'd0);
        check("rst_state",       32'(dbg_state),    32'(ST_IDLE));
        check("rst_start",       32'(chain_start),  32'd0);
        check("rst_sample",      32'(chain_sample), 32'd0);
        check("rst_gain_out",    32'(gain_out),     32'd0);
        check("rst_gain_valid",  32'(gain_valid),   32'd0);
        check("rst_overrun",     32'(overrun),      32'd0);
        check("rst_timeout_err", 32'(timeout_err),  32'd0);

        // 1: single request on ch2, latency and gain write-back
        model_delay = 40;
        push_issue(12'hC00, 2'd3);
        push_gain(2, 12'hC00);
        load_ch(2, 12'hC00, 2'd3);
        strobe();
        check("t1_start_t1", 32'(chain_start), 32'd0);
        tick(1);
        check("t1_start_t2", 32'(chain_start), 32'd1);
        check("t1_sample",   32'(chain_sample), 32'hC00);
        drain("t1_drain", 200);
        check("t1_gain2",    32'(gain_out[2*GW +: GW]), 32'h1DB);
        check("t1_gv_count", 32'(gv_cnt[2]), 32'd1);
        check("t1_gv_lat",   32'(gv_cyc - done_cyc), 32'd2);

        // 2: all four at once after reset -> 0,1,2,3; then ch1+ch3 -> 1,3
        do_reset();
        model_delay = 5;
        push_issue(12'd100,  2'd0); push_gain(0, 12'd100);
        push_issue(12'hF38,  2'd1); push_gain(1, 12'hF38);
        push_issue(12'd300,  2'd2); push_gain(2, 12'd300);
        push_issue(12'hE70,  2'd3); push_gain(3, 12'hE70);
        load_ch(0, 12'd100, 2'd0);
        load_ch(1, 12'hF38, 2'd1);
        load_ch(2, 12'd300, 2'd2);
        load_ch(3, 12'hE70, 2'd3);
        strobe();
        drain("t2_drain_a", 300);
        push_issue(12'd55,  2'd2); push_gain(1, 12'd55);
        push_issue(12'hFBE, 2'd1); push_gain(3, 12'hFBE);
        load_ch(1, 12'd55,  2'd2);
        load_ch(3, 12'hFBE, 2'd1);
        strobe();
        drain("t2_drain_b", 300);
        check("t2_overrun", 32'(overrun), 32'd0);

        // 3: ch0 overwritten while queued behind a busy chain
        model_delay = 40;
        push_issue(12'd11, 2'd1);  push_gain(1, 12'd11);
        push_issue(12'hD44, 2'd2); push_gain(0, 12'hD44);
        load_ch(1, 12'd11, 2'd1);
        strobe();
        tick(3);
        load_ch(0, 12'd700, 2'd0);
        strobe();
        check("t3_overrun_first", 32'(overrun), 32'd0);
        tick(4);
        load_ch(0, 12'hD44, 2'd2);
        strobe();
        check("t3_overrun_set", 32'(overrun), 32'b0001);
        drain("t3_drain", 300);
        check("t3_overrun_sticky", 32'(overrun), 32'b0001);
        clear_flags = 1'b1;
        strobe();
        check("t3_overrun_clr", 32'(overrun), 32'd0);

        // 4: spurious done in IDLE, then done held for 3 cycles
        gv_before = gv_total;
        spur_len  = 3;
        spur_go   = spur_go + 1;
        tick(2);
        check("t4_spur_busy",  32'(busy), 32'd0);
        tick(4);
        check("t4_spur_state", 32'(dbg_state), 32'(ST_IDLE));
        check("t4_spur_gv",    32'(gv_total - gv_before), 32'd0);
        model_delay = 8;
        model_hold  = 3;
        push_issue(12'hED4, 2'd1); push_gain(3, 12'hED4);
        load_ch(3, 12'hED4, 2'd1);
        strobe();
        drain("t4_drain", 200);
        tick(6);
        check("t4_one_store", 32'(gv_total - gv_before), 32'd1);
        check("t4_idle",      32'(busy), 32'd0);
        model_hold = 1;

        // 5: asynchronous reset in the middle of WAIT
        model_delay = 40;
        gv_before   = gv_total;
        push_issue(12'd123, 2'd2);
        load_ch(2, 12'd123, 2'd2);
        strobe();
        tick(10);
        check("t5_in_wait", 32'(dbg_state), 32'(ST_WAIT));
        load_ch(3, 12'd5, 2'd0);
        strobe();
        tick(2);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("t5_busy",     32'(busy),         32'd0);
        check("t5_state",    32'(dbg_state),    32'(ST_IDLE));
        check("t5_sample",   32'(chain_sample), 32'd0);
        check("t5_gain_out", 32'(gain_out),     32'd0);
        check("t5_gv",       32'(gain_valid),   32'd0);
        exp_iss_q.delete();
        exp_gv_q.delete();
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick(60);
        check("t5_no_issue", 32'(dbg_state), 32'(ST_IDLE));
        check("t5_no_gv",    32'(gv_total - gv_before), 32'd0);

        // 6: chain never completes
        model_en = 1'b0;
`ifdef COMP_SCHED_TIMEOUT_EN
        push_issue(12'd77, 2'd0);
        push_issue(12'd88, 2'd1);
        load_ch(0, 12'd77, 2'd0);
        load_ch(1, 12'd88, 2'd1);
        strobe();
        n_wait = 0;
        @(negedge clock);
        while (!chain_start && n_wait < 10) begin
            @(negedge clock);
            n_wait++;
        end
        check("t6_started", 32'(chain_start), 32'd1);
        repeat (TO) @(negedge clock);
        check("t6_wait_last", 32'(busy), 32'd1);
        @(negedge clock);
        check("t6_idle",      32'(busy), 32'd0);
        check("t6_to_err",    32'(timeout_err), 32'd1);
        @(negedge clock);
        check("t6_next_issue", 32'(chain_start), 32'd1);
        @(posedge clock);
        #1;
        drain("t6_drain", 100);
        check("t6_gv_none", 32'(gain_valid), 32'd0);
        clear_flags = 1'b1;
        strobe();
        check("t6_to_clr", 32'(timeout_err), 32'd0);
`else
        push_issue(12'd77, 2'd0);
        load_ch(0, 12'd77, 2'd0);
        strobe();
        tick(100);
        check("t6_busy_hold", 32'(busy), 32'd1);
        check("t6_state",     32'(dbg_state), 32'(ST_WAIT));
        check("t6_no_to_err", 32'(timeout_err), 32'd0);
        check("t6_issued",    32'(exp_iss_q.size()), 32'd0);
        do_reset();
`endif
        model_en = 1'b1;
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
